// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory slave for the RV32I core data port. It holds a word-organised
//   RAM and a 256-byte MMIO page with these registers:
//     - a 64-bit mtime counter and an mtimecmp compare register
//     - a GPIO output register
//     - a bus-error capture register
//   Every cycle is a read. Read data appears one cycle after the address and
//   reads old data when the same word is written in that cycle.
// Ports
//   clk_in        : clock, all state on rising edge
//   rst_in        : synchronous reset, active high
//   dmaddr_in     : byte address (bits [1:0] ignored for decode)
//   dmdata_in     : write data, byte lanes already positioned
//   dmwr_mask_in  : byte-lane write enables
//   dmwr_req_in   : write strobe
//   dmdata_out    : read data for the address presented the previous cycle
//   gpio_out      : GPIO output register
//   timer_irq_out : registered (mtime >= mtimecmp)
//   bus_err_out   : sticky unmapped-access flag
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] dmaddr_in,
  input  logic [31:0] dmdata_in,
  input  logic [3:0]  dmwr_mask_in,
  input  logic        dmwr_req_in,
  output logic [31:0] dmdata_out,
  output logic [31:0] gpio_out,
  output logic        timer_irq_out,
  output logic        bus_err_out
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [2:0] {
    REG_MTIME_LO,
    REG_MTIME_HI,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_GPIO,
    REG_ERR_ADDR,
    REG_NONE
  } mmio_reg_e;

  typedef enum logic {
    RSEL_REG,
    RSEL_RAM
  } rsel_e;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  mask);
    logic [31:0] r;
    r = old_w;
    for (int unsigned i = 0; i < 4; i++) begin
      if (mask[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   ram_rd_q;
  logic [AW-1:0] ram_idx;

  logic [63:0] mtime_q, mtime_d, mtime_inc;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] gpio_q, gpio_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic        err_q, err_d;
  logic        irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;
  rsel_e       rsel_q, rsel_d;

  logic        ram_hit;
  logic        unmapped;
  mmio_reg_e   mmio_reg;
  logic [31:0] mmio_rdata;
  logic        reg_wr;

  // Address decode
  always_comb begin
    ram_hit  = (dmaddr_in[31:AW+2] == RAM_BASE[31:AW+2]);
    ram_idx  = dmaddr_in[AW+1:2];
    mmio_reg = REG_NONE;
    if (!ram_hit && (dmaddr_in[31:8] == MMIO_BASE[31:8])) begin
      case (dmaddr_in[7:2])
        6'd0:    mmio_reg = REG_MTIME_LO;
        6'd1:    mmio_reg = REG_MTIME_HI;
        6'd2:    mmio_reg = REG_CMP_LO;
        6'd3:    mmio_reg = REG_CMP_HI;
        6'd4:    mmio_reg = REG_GPIO;
        6'd5:    mmio_reg = REG_ERR_ADDR;
        default: mmio_reg = REG_NONE;
      endcase
    end
    unmapped = !ram_hit && (mmio_reg == REG_NONE);
    reg_wr   = dmwr_req_in && (dmwr_mask_in != 4'b0000);
  end

  // MMIO read mux, sampled before this edge's updates (read-first)
  always_comb begin
    mmio_rdata = '0;
    case (mmio_reg)
      REG_MTIME_LO: mmio_rdata = mtime_q[31:0];
      REG_MTIME_HI: mmio_rdata = mtime_q[63:32];
      REG_CMP_LO:   mmio_rdata = mtimecmp_q[31:0];
      REG_CMP_HI:   mmio_rdata = mtimecmp_q[63:32];
      REG_GPIO:     mmio_rdata = gpio_q;
      REG_ERR_ADDR: mmio_rdata = err_addr_q;
      default:      mmio_rdata = '0;
    endcase
  end

  // Next-state logic
  always_comb begin
    mtime_inc  = mtime_q + 64'd1;
    // Written lanes override the incremented value. The hi half comes from
    // the full 64-bit increment, so a carry out of lo still lands there.
    mtime_d    = mtime_inc;
    mtimecmp_d = mtimecmp_q;
    gpio_d     = gpio_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;

    if (dmwr_req_in) begin
      case (mmio_reg)
        REG_MTIME_LO: mtime_d[31:0]     = lane_merge(mtime_inc[31:0], dmdata_in, dmwr_mask_in);
        REG_MTIME_HI: mtime_d[63:32]    = lane_merge(mtime_inc[63:32], dmdata_in, dmwr_mask_in);
        REG_CMP_LO:   mtimecmp_d[31:0]  = lane_merge(mtimecmp_q[31:0], dmdata_in, dmwr_mask_in);
        REG_CMP_HI:   mtimecmp_d[63:32] = lane_merge(mtimecmp_q[63:32], dmdata_in, dmwr_mask_in);
        REG_GPIO:     gpio_d            = lane_merge(gpio_q, dmdata_in, dmwr_mask_in);
        default:      ;
      endcase
    end

    if (reg_wr && (mmio_reg == REG_ERR_ADDR)) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end else if (unmapped && !err_q) begin
      err_d      = 1'b1;
      err_addr_d = dmaddr_in;
    end

    irq_d   = (mtime_q >= mtimecmp_q);
    rsel_d  = ram_hit ? RSEL_RAM : RSEL_REG;
    rdata_d = mmio_rdata;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      gpio_q     <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
      rsel_q     <= RSEL_REG;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      gpio_q     <= gpio_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
      rsel_q     <= rsel_d;
    end
  end

  // RAM: no reset on contents; writes suppressed during reset
  always_ff @(posedge clk_in) begin
    ram_rd_q <= mem[ram_idx];
    if (!rst_in && dmwr_req_in && ram_hit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (dmwr_mask_in[i]) mem[ram_idx][8*i +: 8] <= dmdata_in[8*i +: 8];
      end
    end
  end

  assign dmdata_out    = (rsel_q == RSEL_RAM) ? ram_rd_q : rdata_q;
  assign gpio_out      = gpio_q;
  assign timer_irq_out = irq_q;
  assign bus_err_out   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wmask = '0;
  logic        wreq = 1'b0;
  logic [31:0] rdata;
  logic [31:0] gpio;
  logic        irq;
  logic        berr;

  localparam int SEL_DATA = 0;
  localparam int SEL_GPIO = 1;
  localparam int SEL_IRQ  = 2;
  localparam int SEL_BERR = 3;

  localparam logic [31:0] MT_LO  = 32'h8000_0000;
  localparam logic [31:0] MT_HI  = 32'h8000_0004;
  localparam logic [31:0] CMP_LO = 32'h8000_0008;
  localparam logic [31:0] CMP_HI = 32'h8000_000C;
  localparam logic [31:0] GPIO_A = 32'h8000_0010;
  localparam logic [31:0] ERR_A  = 32'h8000_0014;

  typedef struct {
    int          sel;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   t      = 0;

  dmem_responder #(
    .DEPTH_WORDS(1024),
    .RAM_BASE(32'h0000_0000),
    .MMIO_BASE(32'h8000_0000)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .dmaddr_in(addr),
    .dmdata_in(wdata),
    .dmwr_mask_in(wmask),
    .dmwr_req_in(wreq),
    .dmdata_out(rdata),
    .gpio_out(gpio),
    .timer_irq_out(irq),
    .bus_err_out(berr)
  );

  always #5 clk = ~clk;

  // Monitor: entries queued during a cycle are checked after the next edge
  initial begin
    int   n;
    exp_t e;
    logic [31:0] act;
    forever begin
      @(posedge clk);
      n = q.size();
      if (n > 0) begin
        @(negedge clk);
        repeat (n) begin
          e = q.pop_front();
          case (e.sel)
            SEL_DATA: act = rdata;
            SEL_GPIO: act = gpio;
            SEL_IRQ:  act = {31'b0, irq};
            default:  act = {31'b0, berr};
          endcase
          n_vec++;
          if (act !== e.val) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", e.nm, act, e.val);
          end
        end
      end
    end
  end

  task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic w);
    @(negedge clk);
    rst   = r;
    addr  = a;
    wdata = d;
    wmask = m;
    wreq  = w;
    if (r) t = 0;
    else   t++;
  endtask

  task automatic expect_out(input int sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.sel = sel;
    e.val = v;
    e.nm  = nm;
    q.push_back(e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    drive(1'b0, a, d, m, 1'b1);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] v, input string nm);
    drive(1'b0, a, 32'h0, 4'h0, 1'b0);
    expect_out(SEL_DATA, v, nm);
  endtask

  initial begin
    // Reset values and basic RAM write/read
    drive(1'b1, 32'h0, 32'h0, 4'h0, 1'b0);
    expect_out(SEL_DATA, 32'h0, "rst_dmdata");
    expect_out(SEL_GPIO, 32'h0, "rst_gpio");
    expect_out(SEL_IRQ,  32'h0, "rst_irq");
    expect_out(SEL_BERR, 32'h0, "rst_berr");
    wr(32'h10, 32'hDEAD_BEEF, 4'hF);
    rd(32'h10, 32'hDEAD_BEEF, "ram_rd");
    rd(32'h13, 32'hDEAD_BEEF, "ram_rd_lowbits");
    wr(32'h10, 32'h0, 4'h0);
    rd(32'h10, 32'hDEAD_BEEF, "mask0_noop");

    // Partial lane write and read-during-write
    wr(32'h20, 32'h1122_3344, 4'hF);
    wr(32'h20, 32'h0000_AB00, 4'b0010);
    expect_out(SEL_DATA, 32'h1122_3344, "rdw_old");
    rd(32'h20, 32'h1122_AB44, "lane_merge");
    rd(32'h0FFC, 32'hx, "ram_top_dummy");
    void'(q.pop_back());
    expect_out(SEL_BERR, 32'h0, "ram_top_mapped");

    // Bus error capture and clear
    rd(32'h4000_0000, 32'h0, "unmapped_rd0");
    expect_out(SEL_BERR, 32'h1, "berr_set");
    rd(32'h5000_0000, 32'h0, "unmapped_rd1");
    rd(ERR_A, 32'h4000_0000, "err_addr_first");
    wr(ERR_A, 32'h0, 4'hF);
    expect_out(SEL_DATA, 32'h4000_0000, "err_rd_during_clr");
    expect_out(SEL_BERR, 32'h0, "berr_clr");
    rd(ERR_A, 32'h0, "err_addr_clr");
    rd(32'h0000_1000, 32'h0, "ram_end_unmapped");
    expect_out(SEL_BERR, 32'h1, "berr_ram_end");
    rd(32'h8000_0018, 32'h0, "mmio_hole");
    rd(ERR_A, 32'h0000_1000, "err_addr_ram_end");
    wr(ERR_A, 32'h0, 4'b0001);
    expect_out(SEL_BERR, 32'h0, "berr_clr2");

    // GPIO lane write
    wr(GPIO_A, 32'hA5A5_A5A5, 4'b1001);
    expect_out(SEL_GPIO, 32'hA500_00A5, "gpio_lanes");
    rd(GPIO_A, 32'hA500_00A5, "gpio_rd");

    // Reset with a write pending: suppressed, RAM kept
    drive(1'b1, 32'h10, 32'h1234_5678, 4'hF, 1'b1);
    expect_out(SEL_GPIO, 32'h0, "rst2_gpio");
    expect_out(SEL_DATA, 32'h0, "rst2_dmdata");
    expect_out(SEL_BERR, 32'h0, "rst2_berr");
    rd(MT_LO, 32'h0, "mtime_after_rst");
    rd(32'h10, 32'hDEAD_BEEF, "ram_kept");

    // Timer compare
    wr(CMP_HI, 32'h0, 4'hF);
    wr(CMP_LO, 32'd20, 4'hF);
    while (t < 23) begin
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      // irq after edge t reflects mtime == t-1 against cmp 20
      expect_out(SEL_IRQ, (t - 1 >= 20) ? 32'h1 : 32'h0, "timer_irq");
    end
    rd(CMP_LO, 32'd20, "cmp_lo_rd");

    // mtime write with carry into hi
    wr(MT_HI, 32'h0, 4'hF);
    wr(MT_LO, 32'hFFFF_FFFF, 4'hF);
    rd(MT_LO, 32'hFFFF_FFFF, "mtime_lo_written");
    rd(MT_LO, 32'h0, "mtime_lo_wrapped");
    rd(MT_HI, 32'h1, "mtime_hi_carry");

    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    n_vec++;
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
